// File: rtl/noekeon_data_in_loader_if.sv
// Host-side word stream into the loader plus the block/start/done handshake
// toward the first cipher round.
//   slave  : the loader (takes words and inDone, presents the block and status)
//   master : the host / core side
interface noekeon_data_in_loader_if;
    logic         inClear;      // synchronous abort of the current block
    logic [31:0]  inWord;       // data word from host
    logic         inWordValid;  // inWord valid this cycle
    logic         outWordReady; // loader accepts a word this cycle
    logic [127:0] outData;      // assembled 128-bit block
    logic         outStart;     // one-cycle pulse: outData complete, core starts
    logic         inDone;       // one-cycle pulse: core finished the block
    logic         outBusy;      // block issued, inDone outstanding
    logic [1:0]   outCount;     // words accepted in the current block

    modport slave (
        input  inClear, inWord, inWordValid, inDone,
        output outWordReady, outData, outStart, outBusy, outCount
    );

    modport master (
        output inClear, inWord, inWordValid, inDone,
        input  outWordReady, outData, outStart, outBusy, outCount
    );
endinterface

// File: rtl/noekeon_data_in_loader.sv
// Collects four 32-bit host words into one 128-bit Noekeon block, pulses
// outStart for one cycle when the block is complete, then holds the block
// until the core reports inDone.
//   inClk, inReset : clock and asynchronous active-high reset
//   bus (slave)    : word stream, block output, start/done handshake, status
//   MSW_FIRST      : 1 = first word lands in [127:96], 0 = first word in [31:0]
module noekeon_data_in_loader #(
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic                      inClk,
    input  logic                      inReset,
    noekeon_data_in_loader_if.slave   bus
);

    localparam int unsigned WordW  = 32;
    localparam int unsigned Words  = 4;
    localparam int unsigned CountW = 2;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2
    } state_t;

    state_t            state;
    state_t            nextState;
    logic              accept;
    logic [CountW-1:0] slot;

    assign accept = bus.inWordValid && bus.outWordReady;

    // With MSW first, word k goes to slot 3-k, which for 2 bits is ~k.
    assign slot = MSW_FIRST ? ~bus.outCount : bus.outCount;

    // State register
    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            state <= COLLECT;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; inClear overrides every transition
    always_comb begin
        nextState = state;
        case (state)
            COLLECT: if (accept && (bus.outCount == CountW'(Words - 1))) nextState = START;
            START:   nextState = BUSY;
            BUSY:    if (bus.inDone) nextState = COLLECT;
            default: nextState = COLLECT;
        endcase
        if (bus.inClear) begin
            nextState = COLLECT;
        end
    end

    // Status outputs decoded from the state register only
    always_comb begin
        bus.outWordReady = 1'b0;
        bus.outStart     = 1'b0;
        bus.outBusy      = 1'b0;
        case (state)
            COLLECT: bus.outWordReady = 1'b1;
            START: begin
                bus.outStart = 1'b1;
                bus.outBusy  = 1'b1;
            end
            BUSY:    bus.outBusy = 1'b1;
            default: bus.outWordReady = 1'b1;
        endcase
    end

    // Block assembly; the count wraps to 0 on the fourth word, so it is
    // already 0 when BUSY returns to COLLECT
    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            bus.outData  <= '0;
            bus.outCount <= '0;
        end else if (bus.inClear) begin
            bus.outData  <= '0;
            bus.outCount <= '0;
        end else if (accept) begin
            for (int i = 0; i < Words; i++) begin
                if (slot == CountW'(i)) begin
                    bus.outData[i*WordW +: WordW] <= bus.inWord;
                end
            end
            bus.outCount <= bus.outCount + CountW'(1);
        end
    end

endmodule

// File: tb/tb_noekeon_data_in_loader.sv
// Directed bench: one loader per word order, both fed the same stimulus.
module tb_noekeon_data_in_loader;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [31:0] word;
    logic        valid;
    logic        done;

    int checks = 0;
    int errors = 0;

    noekeon_data_in_loader_if bus1 ();
    noekeon_data_in_loader_if bus0 ();

    assign bus1.inClear     = clear;
    assign bus1.inWord      = word;
    assign bus1.inWordValid = valid;
    assign bus1.inDone      = done;
    assign bus0.inClear     = clear;
    assign bus0.inWord      = word;
    assign bus0.inWordValid = valid;
    assign bus0.inDone      = done;

    noekeon_data_in_loader #(.MSW_FIRST(1'b1)) dut1 (
        .inClk   (clk),
        .inReset (rst),
        .bus     (bus1)
    );

    noekeon_data_in_loader #(.MSW_FIRST(1'b0)) dut0 (
        .inClk   (clk),
        .inReset (rst),
        .bus     (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Control/status of the MSW-first instance
    task automatic chkCtl(input string tag, input logic rdy, input logic st,
                          input logic bsy, input logic [1:0] cnt);
        chk({tag, ".ready"}, 128'(bus1.outWordReady), 128'(rdy));
        chk({tag, ".start"}, 128'(bus1.outStart), 128'(st));
        chk({tag, ".busy"},  128'(bus1.outBusy), 128'(bsy));
        chk({tag, ".count"}, 128'(bus1.outCount), 128'(cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [31:0] w);
        valid = 1'b1;
        word  = w;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        word  = '0;
        valid = 1'b0;
        done  = 1'b0;

        // Reset state, and no word taken while reset is held
        #3;
        chkCtl("rst", 1'b1, 1'b0, 1'b0, 2'd0);
        chk("rst.data", bus1.outData, 128'h0);
        valid = 1'b1;
        word  = 32'hDEADBEEF;
        tick();
        tick();
        chk("rst.noaccept.count", 128'(bus1.outCount), 128'(0));
        chk("rst.noaccept.data", bus1.outData, 128'h0);
        valid = 1'b0;
        rst   = 1'b0;
        tick();

        // First block, both word orders
        sendWord(32'h00112233);
        chkCtl("b1.w1", 1'b1, 1'b0, 1'b0, 2'd1);
        sendWord(32'h44556677);
        sendWord(32'h8899AABB);
        chkCtl("b1.w3", 1'b1, 1'b0, 1'b0, 2'd3);
        sendWord(32'hCCDDEEFF);
        chkCtl("b1.start", 1'b0, 1'b1, 1'b1, 2'd0);
        chk("b1.data.msw", bus1.outData, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        chk("b1.data.lsw", bus0.outData, 128'hCCDDEEFF_8899AABB_44556677_00112233);
        tick();
        chkCtl("b1.busy", 1'b0, 1'b0, 1'b1, 2'd0);
        chk("b1.busy.data", bus1.outData, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // Valid held during BUSY is not taken
        valid = 1'b1;
        word  = 32'h55555555;
        tick();
        tick();
        chkCtl("busy.hold", 1'b0, 1'b0, 1'b1, 2'd0);
        chk("busy.hold.data", bus1.outData, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        done = 1'b1;
        tick();
        done = 1'b0;
        chkCtl("done.ready", 1'b1, 1'b0, 1'b0, 2'd0);
        chk("done.data", bus1.outData, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // Next word into slot 0; gaps hold state
        sendWord(32'hA1A1A1A1);
        chkCtl("gap.w1", 1'b1, 1'b0, 1'b0, 2'd1);
        chk("gap.w1.data", bus1.outData, 128'hA1A1A1A1_44556677_8899AABB_CCDDEEFF);
        tick();
        tick();
        tick();
        chkCtl("gap.idle", 1'b1, 1'b0, 1'b0, 2'd1);
        sendWord(32'hB2B2B2B2);
        chkCtl("gap.w2", 1'b1, 1'b0, 1'b0, 2'd2);
        chk("gap.w2.msw", bus1.outData, 128'hA1A1A1A1_B2B2B2B2_8899AABB_CCDDEEFF);
        chk("gap.w2.lsw", bus0.outData, 128'hCCDDEEFF_8899AABB_B2B2B2B2_A1A1A1A1);

        // Spurious inDone in COLLECT
        done = 1'b1;
        tick();
        done = 1'b0;
        chkCtl("spurious", 1'b1, 1'b0, 1'b0, 2'd2);
        chk("spurious.data", bus1.outData, 128'hA1A1A1A1_B2B2B2B2_8899AABB_CCDDEEFF);

        // inClear beats a fourth-word accept
        sendWord(32'hC3C3C3C3);
        chkCtl("clr.pre", 1'b1, 1'b0, 1'b0, 2'd3);
        clear = 1'b1;
        valid = 1'b1;
        word  = 32'hD4D4D4D4;
        tick();
        clear = 1'b0;
        valid = 1'b0;
        chkCtl("clr", 1'b1, 1'b0, 1'b0, 2'd0);
        chk("clr.data", bus1.outData, 128'h0);
        tick();
        chkCtl("clr.after", 1'b1, 1'b0, 1'b0, 2'd0);

        // Back-to-back blocks, inDone two edges after outStart
        sendWord(32'h01234567);
        sendWord(32'h89ABCDEF);
        sendWord(32'hFEDCBA98);
        sendWord(32'h76543210);
        chkCtl("bb1.start", 1'b0, 1'b1, 1'b1, 2'd0);
        chk("bb1.data", bus1.outData, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
        tick();
        chkCtl("bb1.busy", 1'b0, 1'b0, 1'b1, 2'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chkCtl("bb1.done", 1'b1, 1'b0, 1'b0, 2'd0);
        sendWord(32'h0F0F0F0F);
        sendWord(32'hF0F0F0F0);
        sendWord(32'h5A5A5A5A);
        chkCtl("bb2.w3", 1'b1, 1'b0, 1'b0, 2'd3);
        sendWord(32'hA5A5A5A5);
        chkCtl("bb2.start", 1'b0, 1'b1, 1'b1, 2'd0);
        chk("bb2.data.msw", bus1.outData, 128'h0F0F0F0F_F0F0F0F0_5A5A5A5A_A5A5A5A5);
        chk("bb2.data.lsw", bus0.outData, 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F);
        tick();
        chkCtl("bb2.busy", 1'b0, 1'b0, 1'b1, 2'd0);
        done = 1'b1;
        tick();
        done = 1'b0;

        // inClear during START kills the block
        sendWord(32'h11111111);
        sendWord(32'h22222222);
        sendWord(32'h33333333);
        sendWord(32'h44444444);
        chkCtl("cs.start", 1'b0, 1'b1, 1'b1, 2'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chkCtl("cs.clr", 1'b1, 1'b0, 1'b0, 2'd0);
        chk("cs.data", bus1.outData, 128'h0);
        tick();
        chkCtl("cs.after", 1'b1, 1'b0, 1'b0, 2'd0);

        // Asynchronous reset between edges while BUSY
        sendWord(32'h66666666);
        sendWord(32'h77777777);
        sendWord(32'h88888888);
        sendWord(32'h99999999);
        tick();
        chkCtl("ar.busy", 1'b0, 1'b0, 1'b1, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        chkCtl("ar.async", 1'b1, 1'b0, 1'b0, 2'd0);
        chk("ar.data", bus1.outData, 128'h0);
        #1;
        rst = 1'b0;
        tick();

        // First word after reset lands in slot 0 of each word order
        sendWord(32'hCAFEF00D);
        chkCtl("ar.w1", 1'b1, 1'b0, 1'b0, 2'd1);
        chk("ar.w1.msw", bus1.outData, 128'hCAFEF00D_00000000_00000000_00000000);
        chk("ar.w1.lsw", bus0.outData, 128'h00000000_00000000_00000000_CAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
